// File: rtl/stream_check_pkg.sv
// Shared types and constants for the stream checker: FSM state encoding,
// compare-mode selectors and a saturating counter helper.
package stream_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic CMP_EXACT = 1'b0;
  localparam logic CMP_TOL   = 1'b1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sample_cmp.sv
// Single-channel sample comparator: exact equality, or signed |a-b| > tol
// evaluated in DATA_WIDTH+1 bits so extreme operands never wrap.
module sample_cmp
  import stream_check_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] tol,
  input  logic                  tol_mode,
  output logic                  mismatch
);

  logic signed [DATA_WIDTH:0] diff;
  logic        [DATA_WIDTH:0] mag;

  always_comb begin
    diff = $signed({a[DATA_WIDTH-1], a}) - $signed({b[DATA_WIDTH-1], b});
    // Negating the most negative difference yields 2^DATA_WIDTH, still exact as unsigned.
    mag  = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    if (tol_mode == CMP_EXACT) begin
      mismatch = (a != b);
    end else begin
      mismatch = (mag > {1'b0, tol});
    end
  end

endmodule

// File: rtl/stream_checker.sv
// Lockstep multi-channel stream checker: pops DUT and expected FWFT FIFOs
// together, counts mismatching sample indices and times out on stalls.
module stream_checker
  import stream_check_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned STALL_LIMIT = 65536
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [31:0]                  num_samples,
  input  logic                         tol_mode,
  input  logic [DATA_WIDTH-1:0]        tol,
  input  logic [NUM_CH*DATA_WIDTH-1:0] dut_data,
  input  logic [NUM_CH-1:0]            dut_empty,
  output logic                         dut_rd_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] exp_data,
  input  logic [NUM_CH-1:0]            exp_empty,
  output logic                         exp_rd_en,
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out,
  output logic [31:0]                  error_count,
  output logic [31:0]                  cycle_count,
  output logic                         first_err_valid,
  output logic [31:0]                  first_err_index,
  output logic [NUM_CH-1:0]            first_err_mask
);

  localparam logic [31:0] STALL_LAST = 32'(STALL_LIMIT - 1);

  state_t state_q, state_d;

  logic [31:0]       sample_idx_q, sample_idx_d;
  logic [31:0]       stall_q, stall_d;
  logic [31:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       cyc_cnt_q, cyc_cnt_d;
  logic              timed_out_q, timed_out_d;
  logic              fe_valid_q, fe_valid_d;
  logic [31:0]       fe_index_q, fe_index_d;
  logic [NUM_CH-1:0] fe_mask_q, fe_mask_d;

  logic [NUM_CH-1:0] ch_mismatch;
  logic              pop;
  logic              any_mismatch;
  logic              start_ok;
  logic              run_end;
  logic              stall_hit;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sample_cmp #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
      .a        (dut_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .b        (exp_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .tol      (tol),
      .tol_mode (tol_mode),
      .mismatch (ch_mismatch[k])
    );
  end

  // Pop is also gated by reset so a reset cycle never consumes a sample.
  always_comb begin
    pop          = !reset && (state_q == ST_RUN) && (sample_idx_q < num_samples)
                   && !(|dut_empty) && !(|exp_empty);
    any_mismatch = pop && (|ch_mismatch);
    start_ok     = start && (state_q != ST_RUN);
    run_end      = (state_q == ST_RUN) && (sample_idx_q == num_samples);
    stall_hit    = (state_q == ST_RUN) && !pop && (stall_q == STALL_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (run_end || stall_hit) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    dut_rd_en = pop;
    exp_rd_en = pop;
  end

  // Datapath next-state
  always_comb begin
    sample_idx_d = sample_idx_q;
    stall_d      = stall_q;
    err_cnt_d    = err_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    timed_out_d  = timed_out_q;
    fe_valid_d   = fe_valid_q;
    fe_index_d   = fe_index_q;
    fe_mask_d    = fe_mask_q;
    if (start_ok) begin
      sample_idx_d = '0;
      stall_d      = '0;
      err_cnt_d    = '0;
      cyc_cnt_d    = '0;
      timed_out_d  = 1'b0;
      fe_valid_d   = 1'b0;
      fe_index_d   = '0;
      fe_mask_d    = '0;
    end else if (state_q == ST_RUN) begin
      cyc_cnt_d = sat_inc32(cyc_cnt_q);
      if (pop) begin
        sample_idx_d = sample_idx_q + 32'd1;
        stall_d      = '0;
        if (any_mismatch) begin
          err_cnt_d = sat_inc32(err_cnt_q);
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_index_d = sample_idx_q;
            fe_mask_d  = ch_mismatch;
          end
        end
      end else begin
        stall_d = sat_inc32(stall_q);
      end
      // Normal completion takes priority over a coincident stall timeout.
      if (stall_hit && !run_end) begin
        timed_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_idx_q <= '0;
      stall_q      <= '0;
      err_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      timed_out_q  <= 1'b0;
      fe_valid_q   <= 1'b0;
      fe_index_q   <= '0;
      fe_mask_q    <= '0;
    end else begin
      sample_idx_q <= sample_idx_d;
      stall_q      <= stall_d;
      err_cnt_q    <= err_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      timed_out_q  <= timed_out_d;
      fe_valid_q   <= fe_valid_d;
      fe_index_q   <= fe_index_d;
      fe_mask_q    <= fe_mask_d;
    end
  end

  assign timed_out       = timed_out_q;
  assign error_count     = err_cnt_q;
  assign cycle_count     = cyc_cnt_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_index = fe_index_q;
  assign first_err_mask  = fe_mask_q;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: FWFT FIFO models feeding two channels,
// hand-computed expectations per scenario.
module tb_stream_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_samples;
  logic        tol_mode;
  logic [31:0] tol;
  logic [63:0] dut_data;
  logic [1:0]  dut_empty;
  logic        dut_rd_en;
  logic [63:0] exp_data;
  logic [1:0]  exp_empty;
  logic        exp_rd_en;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [31:0] error_count;
  logic [31:0] cycle_count;
  logic        first_err_valid;
  logic [31:0] first_err_index;
  logic [1:0]  first_err_mask;

  logic [31:0] dmem0 [0:63];
  logic [31:0] dmem1 [0:63];
  logic [31:0] emem0 [0:63];
  logic [31:0] emem1 [0:63];
  logic [5:0]  ptr;
  logic [5:0]  dut_avail;
  logic [5:0]  exp_avail;
  logic        fifo_clear;
  logic        toggle_en;
  logic        force_e0;
  int          viol;

  int n_pass  = 0;
  int n_total = 0;

  stream_checker #(
    .DATA_WIDTH (32),
    .NUM_CH     (2),
    .STALL_LIMIT(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_samples    (num_samples),
    .tol_mode       (tol_mode),
    .tol            (tol),
    .dut_data       (dut_data),
    .dut_empty      (dut_empty),
    .dut_rd_en      (dut_rd_en),
    .exp_data       (exp_data),
    .exp_empty      (exp_empty),
    .exp_rd_en      (exp_rd_en),
    .busy           (busy),
    .done           (done),
    .timed_out      (timed_out),
    .error_count    (error_count),
    .cycle_count    (cycle_count),
    .first_err_valid(first_err_valid),
    .first_err_index(first_err_index),
    .first_err_mask (first_err_mask)
  );

  always #5 clk = ~clk;

  assign dut_data  = {dmem1[ptr], dmem0[ptr]};
  assign exp_data  = {emem1[ptr], emem0[ptr]};
  assign dut_empty = {(ptr >= dut_avail), (ptr >= dut_avail) | force_e0};
  assign exp_empty = {2{ptr >= exp_avail}};

  always @(posedge clk) begin
    if (fifo_clear) ptr <= '0;
    else if (dut_rd_en) ptr <= ptr + 6'd1;
  end

  always @(posedge clk) begin
    if (toggle_en) force_e0 <= ~force_e0;
    else force_e0 <= 1'b0;
  end

  always @(negedge clk) begin
    if ((dut_rd_en || exp_rd_en) && ((|dut_empty) || (|exp_empty) || (dut_rd_en != exp_rd_en)))
      viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_clean(input int n);
    for (int i = 0; i < 64; i++) begin
      dmem0[i] = 32'h1000_0000 + 32'(i);
      emem0[i] = 32'h1000_0000 + 32'(i);
      dmem1[i] = 32'h2000_0000 + 32'(i * 3);
      emem1[i] = 32'h2000_0000 + 32'(i * 3);
    end
    dut_avail  = 6'(n);
    exp_avail  = 6'(n);
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
  endtask

  task automatic run_and_wait(input int again_at, output int cycles);
    start = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 300) begin
      start = (cycles == again_at);
      tick();
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_clean(16);
    tick();
    tick();
    n_total++; if ({busy, done, timed_out, first_err_valid, dut_rd_en, exp_rd_en} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {busy, done, timed_out, first_err_valid, dut_rd_en, exp_rd_en});
    else n_pass++;
    n_total++; if ({error_count, cycle_count, first_err_index} !== 96'd0 || first_err_mask !== 2'b00)
      $display("FAIL reset_counts got %h %h %h %b want zeros", error_count, cycle_count, first_err_index, first_err_mask);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (busy !== 1'b0 || dut_rd_en !== 1'b0)
      $display("FAIL idle_no_pop got busy=%b rd=%b want 0 0", busy, dut_rd_en);
    else n_pass++;
  endtask

  task automatic test_exact_match();
    int cyc;
    load_clean(16);
    num_samples = 32'd16;
    tol_mode    = 1'b0;
    tol         = 32'd0;
    run_and_wait(4, cyc);
    n_total++; if (cyc !== 17) $display("FAIL exact_latency got %0d want 17", cyc); else n_pass++;
    n_total++; if (error_count !== 32'd0 || first_err_valid !== 1'b0)
      $display("FAIL exact_errors got %0d/%b want 0/0", error_count, first_err_valid);
    else n_pass++;
    n_total++; if (cycle_count !== 32'd17 || ptr !== 6'd16 || timed_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL exact_state got cc=%0d pops=%0d to=%b busy=%b want 17 16 0 0", cycle_count, ptr, timed_out, busy);
    else n_pass++;
  endtask

  task automatic test_single_mismatch();
    int cyc;
    load_clean(16);
    emem1[5] = 32'h0000_0010;
    dmem1[5] = 32'h0000_0011;
    run_and_wait(-1, cyc);
    n_total++; if (error_count !== 32'd1) $display("FAIL single_count got %0d want 1", error_count); else n_pass++;
    n_total++; if (first_err_valid !== 1'b1 || first_err_index !== 32'd5 || first_err_mask !== 2'b10)
      $display("FAIL single_first got %b idx=%0d mask=%b want 1 5 10", first_err_valid, first_err_index, first_err_mask);
    else n_pass++;
  endtask

  task automatic test_multi_mismatch();
    int cyc;
    load_clean(16);
    dmem0[2] = 32'hDEAD_0000;
    dmem1[2] = 32'hBEEF_0000;
    dmem0[9] = 32'h0;
    run_and_wait(-1, cyc);
    n_total++; if (error_count !== 32'd2) $display("FAIL multi_count got %0d want 2", error_count); else n_pass++;
    n_total++; if (first_err_index !== 32'd2 || first_err_mask !== 2'b11)
      $display("FAIL multi_first got idx=%0d mask=%b want 2 11", first_err_index, first_err_mask);
    else n_pass++;
  endtask

  task automatic test_restart_clears();
    int cyc;
    load_clean(4);
    num_samples = 32'd4;
    run_and_wait(-1, cyc);
    n_total++; if (error_count !== 32'd0 || first_err_valid !== 1'b0 || first_err_mask !== 2'b00 || cycle_count !== 32'd5)
      $display("FAIL restart_clear got err=%0d fev=%b mask=%b cc=%0d want 0 0 00 5", error_count, first_err_valid, first_err_mask, cycle_count);
    else n_pass++;
  endtask

  task automatic test_tolerance();
    int cyc;
    tol_mode    = 1'b1;
    tol         = 32'd1;
    num_samples = 32'd4;
    load_clean(4);
    dmem0[0] = 32'hFFFF_FFFF;
    emem0[0] = 32'h0000_0000;
    dmem1[2] = 32'h0000_0004;
    emem1[2] = 32'h0000_0003;
    run_and_wait(-1, cyc);
    n_total++; if (error_count !== 32'd0 || first_err_valid !== 1'b0)
      $display("FAIL tol_within got err=%0d fev=%b want 0 0", error_count, first_err_valid);
    else n_pass++;
    load_clean(4);
    dmem1[1] = 32'h7FFF_FFFF;
    emem1[1] = 32'h8000_0000;
    dmem0[3] = 32'h0000_0005;
    emem0[3] = 32'h0000_0003;
    run_and_wait(-1, cyc);
    n_total++; if (error_count !== 32'd2) $display("FAIL tol_nowrap_count got %0d want 2", error_count); else n_pass++;
    n_total++; if (first_err_index !== 32'd1 || first_err_mask !== 2'b10)
      $display("FAIL tol_nowrap_first got idx=%0d mask=%b want 1 10", first_err_index, first_err_mask);
    else n_pass++;
    tol_mode = 1'b0;
    tol      = 32'd0;
  endtask

  task automatic test_backpressure();
    int cyc;
    load_clean(8);
    num_samples = 32'd8;
    viol        = 0;
    toggle_en   = 1'b1;
    run_and_wait(-1, cyc);
    toggle_en = 1'b0;
    n_total++; if (viol !== 0) $display("FAIL bp_pop_rule got %0d bad pops want 0", viol); else n_pass++;
    n_total++; if (ptr !== 6'd8 || error_count !== 32'd0 || timed_out !== 1'b0 || done !== 1'b1)
      $display("FAIL bp_result got pops=%0d err=%0d to=%b done=%b want 8 0 0 1", ptr, error_count, timed_out, done);
    else n_pass++;
    n_total++; if (!(cycle_count >= 32'd16))
      $display("FAIL bp_throttle got cc=%0d want >=16", cycle_count);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc;
    load_clean(16);
    dut_avail   = 6'd3;
    num_samples = 32'd16;
    run_and_wait(-1, cyc);
    n_total++; if (done !== 1'b1 || timed_out !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_flags got done=%b to=%b busy=%b want 1 1 0", done, timed_out, busy);
    else n_pass++;
    n_total++; if (ptr !== 6'd3 || cycle_count !== 32'd11 || cyc !== 11)
      $display("FAIL timeout_counts got pops=%0d cc=%0d lat=%0d want 3 11 11", ptr, cycle_count, cyc);
    else n_pass++;
  endtask

  task automatic test_zero_samples();
    int cyc;
    load_clean(16);
    num_samples = 32'd0;
    run_and_wait(-1, cyc);
    n_total++; if (cyc !== 1 || ptr !== 6'd0 || timed_out !== 1'b0 || cycle_count !== 32'd1)
      $display("FAIL zero_samples got lat=%0d pops=%0d to=%b cc=%0d want 1 0 0 1", cyc, ptr, timed_out, cycle_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int w;
    load_clean(16);
    dmem0[3] = 32'h0;
    num_samples = 32'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (ptr !== 6'd7 && w < 100) begin
      tick();
      w++;
    end
    n_total++; if (ptr !== 6'd7 || error_count !== 32'd1)
      $display("FAIL midrun_reach got pops=%0d err=%0d want 7 1", ptr, error_count);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_total++; if (ptr !== 6'd7 || busy !== 1'b0 || done !== 1'b0 || error_count !== 32'd0 || cycle_count !== 32'd0 || first_err_valid !== 1'b0)
      $display("FAIL midrun_abort got pops=%0d busy=%b done=%b err=%0d cc=%0d fev=%b want 7 0 0 0 0 0",
               ptr, busy, done, error_count, cycle_count, first_err_valid);
    else n_pass++;
    load_clean(16);
    run_and_wait(-1, cyc);
    n_total++; if (done !== 1'b1 || error_count !== 32'd0 || cycle_count !== 32'd17 || ptr !== 6'd16)
      $display("FAIL midrun_restart got done=%b err=%0d cc=%0d pops=%0d want 1 0 17 16", done, error_count, cycle_count, ptr);
    else n_pass++;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    tol_mode    = 1'b0;
    tol         = '0;
    fifo_clear  = 1'b1;
    toggle_en   = 1'b0;
    dut_avail   = '0;
    exp_avail   = '0;
    viol        = 0;
    test_reset();
    test_exact_match();
    test_single_mismatch();
    test_multi_mismatch();
    test_restart_clears();
    test_tolerance();
    test_backpressure();
    test_timeout();
    test_zero_samples();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per channel sample.
REQ-002 SHALL have parameter NUM_CH, default 2, number of lockstep channels (2 = left/right audio).
REQ-003 SHALL have parameter STALL_LIMIT, default 65536, idle cycles in RUN before timeout.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a check run.
REQ-007 SHALL have port num_samples  in  32  samples per channel to compare in one run.
REQ-008 SHALL have port tol_mode  in  1  0 = exact compare, 1 = tolerance compare.
REQ-009 SHALL have port tol  in  DATA_WIDTH  unsigned max allowed |dut-exp| when tol_mode=1.
REQ-010 SHALL have port dut_data  in  NUM_CH*DATA_WIDTH  DUT FIFO heads; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port dut_empty  in  NUM_CH  DUT FIFO empty flags.
REQ-012 SHALL have port dut_rd_en  out  1  common pop for all DUT FIFOs.
REQ-013 SHALL have port exp_data  in  NUM_CH*DATA_WIDTH  expected-value FIFO heads, same packing.
REQ-014 SHALL have port exp_empty  in  NUM_CH  expected FIFO empty flags.
REQ-015 SHALL have port exp_rd_en  out  1  common pop for all expected FIFOs.
REQ-016 SHALL have outputs busy (1), done (1), timed_out (1), error_count (32), cycle_count (32), first_err_valid (1), first_err_index (32), first_err_mask (NUM_CH).

Function
REQ-017 SHALL treat all input FIFOs as first-word-fall-through: head valid while empty=0, consumed on the cycle rd_en=1.
REQ-018 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when sample_idx==num_samples or stall counter==STALL_LIMIT; DONE -> RUN on start; any state -> IDLE on reset.
REQ-019 SHALL, on start accepted in IDLE or DONE, clear error_count, cycle_count, sample_idx, stall counter, timed_out, first_err_*, and done.
REQ-020 SHALL ignore start while in RUN.
REQ-021 SHALL assert dut_rd_en and exp_rd_en combinationally and identically iff state=RUN, sample_idx<num_samples, all dut_empty=0 and all exp_empty=0.
REQ-022 SHALL, on each pop, compare every channel in the same cycle; mismatch = (dut!=exp) if tol_mode=0, else |dut-exp|>tol with operands signed and difference in DATA_WIDTH+1 bits (no wrap).
REQ-023 SHALL increment error_count by 1 per popped sample index with any channel mismatch (not per channel), saturating at 32'hFFFF_FFFF.
REQ-024 SHALL, on the first mismatching pop of a run, register first_err_valid=1, first_err_index=sample_idx (0-based), first_err_mask=per-channel mismatch bits; later mismatches leave them unchanged.
REQ-025 SHALL increment sample_idx per pop; outputs reflect a pop one cycle later (registered, latency 1).
REQ-026 SHALL increment cycle_count every cycle in RUN, saturating.
REQ-027 SHALL reset the stall counter on each pop and increment it on every other RUN cycle; reaching STALL_LIMIT sets timed_out=1 and enters DONE.
REQ-028 SHALL, with num_samples=0, enter DONE one cycle after start with zero pops and timed_out=0.
REQ-029 SHALL drive busy=1 exactly in RUN and done=1 exactly in DONE.
REQ-030 SHALL complete normal and timeout termination in the same cycle if both hit; normal termination wins (timed_out=0).

Reset
REQ-031 SHALL, on reset, go to IDLE and drive all outputs 0, including rd_en, counters and first_err_*.
REQ-032 SHALL abort a run on reset mid-RUN with no further pops from the next cycle.

Structure
REQ-033 SHALL place the state typedef (IDLE/RUN/DONE) and compare-mode constants in shared package stream_check_pkg.
REQ-034 SHALL instantiate NUM_CH copies of combinational sub-module sample_cmp (DATA_WIDTH parameter; a, b, tol, tol_mode -> mismatch).

Verification
REQ-035 SHALL test exact match: NUM_CH=2, num_samples=16, identical streams, FIFOs never empty -> done after 17 cycles, error_count=0, first_err_valid=0.
REQ-036 SHALL test single mismatch: sample 5 ch1 exp 0x0000_0010 vs dut 0x0000_0011, tol_mode=0 -> error_count=1, first_err_index=5, first_err_mask=2'b10.
REQ-037 SHALL test tolerance: tol=1, dut=0xFFFF_FFFF (-1) vs exp 0x0000_0000 -> no error; dut=0x7FFF_FFFF vs exp 0x8000_0000 -> error (no wrap).
REQ-038 SHALL test backpressure: dut_empty[0] toggling every other cycle -> pops only when all non-empty, order preserved, error_count=0.
REQ-039 SHALL test timeout: STALL_LIMIT=8, DUT FIFO empty after 3 samples -> timed_out=1, done=1, sample_idx stays 3, cycle_count=11.
REQ-040 SHALL test reset mid-RUN at sample 7, then restart with start -> counters cleared, new run completes normally.
